// File: rtl/serv_rf_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : serv_rf_ram_arb
// Purpose  : Two-requester arbiter (core / FPU) in front of one RF RAM port.
//            RF_ARB_FIXED_PRIO_EN: core always wins ties (no round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module serv_rf_ram_arb #(
  parameter int W   = 1,
  parameter int RAW = 6,
  parameter int LEN = 36
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_rreq,
  input  logic [1:0]       i_req_wreq,
  output logic [1:0]       o_req_ready,
  input  logic [2*RAW-1:0] i_req_rreg0,
  input  logic [2*RAW-1:0] i_req_rreg1,
  input  logic [2*RAW-1:0] i_req_wreg0,
  input  logic [2*RAW-1:0] i_req_wreg1,
  input  logic [1:0]       i_req_wen0,
  input  logic [1:0]       i_req_wen1,
  input  logic [2*W-1:0]   i_req_wdata0,
  input  logic [2*W-1:0]   i_req_wdata1,
  output logic [W-1:0]     o_req_rdata0,
  output logic [W-1:0]     o_req_rdata1,
  output logic             o_rreq,
  output logic             o_wreq,
  input  logic             i_ready,
  output logic [RAW-1:0]   o_rreg0,
  output logic [RAW-1:0]   o_rreg1,
  output logic [RAW-1:0]   o_wreg0,
  output logic [RAW-1:0]   o_wreg1,
  output logic             o_wen0,
  output logic             o_wen1,
  output logic [W-1:0]     o_wdata0,
  output logic [W-1:0]     o_wdata1,
  input  logic [W-1:0]     i_rdata0,
  input  logic [W-1:0]     i_rdata1,
  output logic             o_busy
);

  localparam int c_cnt_w = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_pend_r;
  logic [1:0]         r_pend_w;
  logic               r_gnt;
  logic               r_rreq;
  logic               r_wreq;
  logic [c_cnt_w-1:0] r_cnt;

  logic [1:0] w_has;
  logic       w_issue;
  logic       w_win;
  logic       w_win_w;
  logic       w_tie_win;
  logic [1:0] w_clr_r;
  logic [1:0] w_clr_w;
  logic       w_ack;
  logic       w_active;

`ifdef RF_ARB_FIXED_PRIO_EN
  assign w_tie_win = 1'b0;
`else
  logic r_last;

  // Requester that was granted most recently; the other one wins a tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_last <= 1'b1;
    else if (w_issue)
      r_last <= w_win;
  end

  assign w_tie_win = ~r_last;
`endif

  assign w_has = r_pend_r | r_pend_w;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_win       = r_gnt;
    w_win_w     = 1'b0;
    w_clr_r     = 2'b00;
    w_clr_w     = 2'b00;
    w_ack       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_has) begin
          w_issue = 1'b1;
          w_win   = (&w_has) ? w_tie_win : w_has[1];
          // Write outranks read within the winning requester.
          w_win_w = r_pend_w[w_win];
          if (w_win_w)
            w_clr_w[w_win] = 1'b1;
          else
            w_clr_r[w_win] = 1'b1;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (i_ready) begin
          w_ack       = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (r_cnt == '0)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A new pulse in the same cycle as an issue-clear re-arms the flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_r <= 2'b00;
      r_pend_w <= 2'b00;
      r_gnt    <= 1'b0;
      r_rreq   <= 1'b0;
      r_wreq   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_pend_r <= (r_pend_r & ~w_clr_r) | i_req_rreq;
      r_pend_w <= (r_pend_w & ~w_clr_w) | i_req_wreq;
      r_rreq   <= w_issue & ~w_win_w;
      r_wreq   <= w_issue & w_win_w;
      if (w_issue)
        r_gnt <= w_win;
      if (w_ack)
        r_cnt <= c_cnt_load;
      else if ((r_state == XFER) && (r_cnt != '0))
        r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  assign w_active    = (r_state != IDLE);
  assign o_busy      = w_active;
  assign o_rreq      = r_rreq;
  assign o_wreq      = r_wreq;
  assign o_req_ready = w_ack ? {r_gnt, ~r_gnt} : 2'b00;

  assign o_rreg0  = r_gnt ? i_req_rreg0[2*RAW-1:RAW] : i_req_rreg0[RAW-1:0];
  assign o_rreg1  = r_gnt ? i_req_rreg1[2*RAW-1:RAW] : i_req_rreg1[RAW-1:0];
  assign o_wreg0  = r_gnt ? i_req_wreg0[2*RAW-1:RAW] : i_req_wreg0[RAW-1:0];
  assign o_wreg1  = r_gnt ? i_req_wreg1[2*RAW-1:RAW] : i_req_wreg1[RAW-1:0];
  assign o_wdata0 = r_gnt ? i_req_wdata0[2*W-1:W] : i_req_wdata0[W-1:0];
  assign o_wdata1 = r_gnt ? i_req_wdata1[2*W-1:W] : i_req_wdata1[W-1:0];
  assign o_wen0   = w_active & i_req_wen0[r_gnt];
  assign o_wen1   = w_active & i_req_wen1[r_gnt];

  assign o_req_rdata0 = i_rdata0;
  assign o_req_rdata1 = i_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_serv_rf_ram_arb
// Purpose  : Directed self-checking bench for serv_rf_ram_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serv_rf_ram_arb;
  localparam int W   = 1;
  localparam int RAW = 6;
  localparam int LEN = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_rst_n = 1'b0;
  logic [1:0]       i_req_rreq = '0, i_req_wreq = '0;
  logic [1:0]       o_req_ready;
  logic [2*RAW-1:0] i_req_rreg0 = '0, i_req_rreg1 = '0, i_req_wreg0 = '0, i_req_wreg1 = '0;
  logic [1:0]       i_req_wen0 = '0, i_req_wen1 = '0;
  logic [2*W-1:0]   i_req_wdata0 = '0, i_req_wdata1 = '0;
  logic [W-1:0]     o_req_rdata0, o_req_rdata1;
  logic             o_rreq, o_wreq;
  logic             i_ready = 1'b0;
  logic [RAW-1:0]   o_rreg0, o_rreg1, o_wreg0, o_wreg1;
  logic             o_wen0, o_wen1;
  logic [W-1:0]     o_wdata0, o_wdata1;
  logic [W-1:0]     i_rdata0 = '0, i_rdata1 = '0;
  logic             o_busy;

  serv_rf_ram_arb #(.W(W), .RAW(RAW), .LEN(LEN)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req_rreq(i_req_rreq), .i_req_wreq(i_req_wreq), .o_req_ready(o_req_ready),
    .i_req_rreg0(i_req_rreg0), .i_req_rreg1(i_req_rreg1),
    .i_req_wreg0(i_req_wreg0), .i_req_wreg1(i_req_wreg1),
    .i_req_wen0(i_req_wen0), .i_req_wen1(i_req_wen1),
    .i_req_wdata0(i_req_wdata0), .i_req_wdata1(i_req_wdata1),
    .o_req_rdata0(o_req_rdata0), .o_req_rdata1(o_req_rdata1),
    .o_rreq(o_rreq), .o_wreq(o_wreq), .i_ready(i_ready),
    .o_rreg0(o_rreg0), .o_rreg1(o_rreg1), .o_wreg0(o_wreg0), .o_wreg1(o_wreg1),
    .o_wen0(o_wen0), .o_wen1(o_wen1), .o_wdata0(o_wdata0), .o_wdata1(o_wdata1),
    .i_rdata0(i_rdata0), .i_rdata1(i_rdata1), .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc - base);
    end
  endtask

  // Background data traffic: addresses, write data and RAM read data.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_req_rreg0  = 12'($urandom);
      i_req_rreg1  = 12'($urandom);
      i_req_wreg0  = 12'($urandom);
      i_req_wreg1  = 12'($urandom);
      i_req_wdata0 = 2'($urandom);
      i_req_wdata1 = 2'($urandom);
      i_rdata0     = 1'($urandom);
      i_rdata1     = 1'($urandom);
    end
  end

  // Transaction model: one grant is live from its issue cycle until LEN
  // cycles after the ready handshake.
  bit         m_act, m_gnt, m_last, m_isw;
  bit [1:0]   m_pr, m_pw;
  int         m_issue, m_rdy;

  function automatic logic [RAW-1:0] slice_a(input logic [2*RAW-1:0] v, input bit g);
    return RAW'(v >> (g * RAW));
  endfunction

  initial begin
    bit [1:0] has;
    bit       w;
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        m_act = 0; m_pr = 0; m_pw = 0; m_gnt = 0; m_last = 1;
        m_isw = 0; m_issue = -10; m_rdy = -1;
      end
      chk("busy",  o_busy, m_act);
      chk("rreq",  o_rreq, m_act && (cyc == m_issue) && !m_isw);
      chk("wreq",  o_wreq, m_act && (cyc == m_issue) && m_isw);
      chk("ready", o_req_ready, (m_act && m_rdy < 0 && i_ready) ? (m_gnt ? 2'b10 : 2'b01) : 2'b00);
      chk("wen",   {o_wen0, o_wen1}, m_act ? {i_req_wen0[m_gnt], i_req_wen1[m_gnt]} : 2'b00);
      chk("addr",  {o_rreg0, o_rreg1, o_wreg0, o_wreg1},
          {slice_a(i_req_rreg0, m_gnt), slice_a(i_req_rreg1, m_gnt),
           slice_a(i_req_wreg0, m_gnt), slice_a(i_req_wreg1, m_gnt)});
      chk("wdata", {o_wdata0, o_wdata1}, {i_req_wdata0[m_gnt], i_req_wdata1[m_gnt]});
      chk("rdata", {o_req_rdata0, o_req_rdata1}, {i_rdata0, i_rdata1});
      if (i_rst_n) begin
        if (!m_act) begin
          has = m_pr | m_pw;
          if (has != 0) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            w = (has == 2'b11) ? 1'b0 : has[1];
`else
            w = (has == 2'b11) ? ~m_last : has[1];
`endif
            m_isw = m_pw[w];
            if (m_isw) m_pw[w] = 0; else m_pr[w] = 0;
            m_gnt = w; m_last = w; m_act = 1; m_issue = cyc + 1; m_rdy = -1;
          end
        end else if (m_rdy < 0) begin
          if (i_ready) m_rdy = cyc;
        end else if (cyc == m_rdy + LEN) begin
          m_act = 0;
        end
        m_pr = m_pr | i_req_rreq;
        m_pw = m_pw | i_req_wreq;
      end
    end
  end

  task automatic at(input int t);
    int g = 0;
    while (cyc < base + t && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic smp(input int t);
    at(t);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    i_rst_n = 0; i_req_rreq = 0; i_req_wreq = 0; i_ready = 0;
    i_req_wen0 = 0; i_req_wen1 = 0;
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1;
    base = cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  bit [1:0] exp_gnt [4];

  initial begin
    int g;
    bit got;

    // Single read from the core
    do_reset();
    smp(1);  chk("t1_reset_busy", o_busy, 1'b0);
    at(5);   i_req_rreq = 2'b01;
    at(6);   i_req_rreq = 2'b00;
    smp(6);  chk("t1_rreq_6", o_rreq, 1'b0);
    smp(7);  chk("t1_rreq_7", o_rreq, 1'b1);
    smp(8);  chk("t1_rreq_8", o_rreq, 1'b0);
    at(9);   i_ready = 1'b1;
    @(negedge clk); chk("t1_ready_9", o_req_ready, 2'b01);
    at(10);  i_ready = 1'b0;
    smp(45); chk("t1_busy_45", o_busy, 1'b1);
    smp(46); chk("t1_busy_46", o_busy, 1'b0);

    // Simultaneous writes from both requesters
    do_reset();
    i_req_wen0 = 2'b10; i_req_wen1 = 2'b01;
    at(5);   i_req_wreq = 2'b11;
    at(6);   i_req_wreq = 2'b00;
    smp(7);  chk("t2_wreq_7", o_wreq, 1'b1);
    chk("t2_wen_r0", {o_wen0, o_wen1}, 2'b01);
    at(8);   i_ready = 1'b1;
    @(negedge clk); chk("t2_ready_8", o_req_ready, 2'b01);
    at(9);   i_ready = 1'b0;
    smp(45); chk("t2_wreq_45", o_wreq, 1'b0);
    smp(46); chk("t2_wreq_46", o_wreq, 1'b1);
    at(48);  i_ready = 1'b1;
    @(negedge clk); chk("t2_ready_48", o_req_ready, 2'b10);
    at(49);  i_ready = 1'b0;
    smp(50); chk("t2_wen_r1", {o_wen0, o_wen1}, 2'b10);
    smp(84); chk("t2_busy_84", o_busy, 1'b1);
    smp(85); chk("t2_busy_85", o_busy, 1'b0);

    // FPU read arriving during the core's transfer
    do_reset();
    at(5);   i_req_rreq = 2'b01;
    at(6);   i_req_rreq = 2'b00;
    at(8);   i_ready = 1'b1;
    at(9);   i_ready = 1'b0;
    at(20);  i_req_rreq = 2'b10;
    at(21);  i_req_rreq = 2'b00;
    smp(46); chk("t3_rreq_46", o_rreq, 1'b1);
    at(47);  i_ready = 1'b1;
    @(negedge clk); chk("t3_ready_47", o_req_ready, 2'b10);
    at(48);  i_ready = 1'b0;

    // Core read+write together; write re-armed in its own issue cycle
    do_reset();
    at(5);   i_req_rreq = 2'b01; i_req_wreq = 2'b01;
    at(6);   i_req_rreq = 2'b00; i_req_wreq = 2'b01;
    at(7);   i_req_wreq = 2'b00;
    @(negedge clk); chk("t4_wreq_7", {o_wreq, o_rreq}, 2'b10);
    at(8);   i_ready = 1'b1;
    at(9);   i_ready = 1'b0;
    smp(46); chk("t4_wreq_46", {o_wreq, o_rreq}, 2'b10);
    at(47);  i_ready = 1'b1;
    at(48);  i_ready = 1'b0;
    smp(85); chk("t4_rreq_85", {o_wreq, o_rreq}, 2'b01);
    at(86);  i_ready = 1'b1;
    @(negedge clk); chk("t4_ready_86", o_req_ready, 2'b01);
    at(87);  i_ready = 1'b0;

    // Reset mid-transfer
    do_reset();
    i_req_wen0 = 2'b01; i_req_wen1 = 2'b01;
    at(5);   i_req_wreq = 2'b01;
    at(6);   i_req_wreq = 2'b00;
    at(8);   i_ready = 1'b1;
    at(9);   i_ready = 1'b0;
    at(20);  i_req_rreq = 2'b10;
    at(21);  i_req_rreq = 2'b00;
    smp(22); chk("t5_wen_pre", {o_wen0, o_wen1, o_busy}, 3'b111);
    at(25);  i_ready = 1'b1; i_rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_wen", {o_wen0, o_wen1}, 2'b00);
    chk("t5_rst_ready", o_req_ready, 2'b00);
    chk("t5_rst_req", {o_rreq, o_wreq}, 2'b00);
    at(27);  i_rst_n = 1'b1; i_ready = 1'b0;
    smp(40); chk("t5_lost", {o_busy, o_rreq}, 2'b00);

    // Repeated ties with i_ready tied high
`ifdef RF_ARB_FIXED_PRIO_EN
    exp_gnt = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_gnt = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    do_reset();
    i_ready = 1'b1;
    at(5);   i_req_rreq = 2'b11;
    at(6);   i_req_rreq = 2'b00;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (o_req_ready == 2'b00 && g < 200);
      if (o_req_ready == 2'b00) begin
        chk("t6_timeout", 1'b1, 1'b0);
        break;
      end
      got = o_req_ready[1];
      chk("t6_gnt", {1'b0, got}, exp_gnt[k]);
      @(posedge clk); #1; i_req_rreq = 2'b11;
      @(posedge clk); #1; i_req_rreq = 2'b00;
    end
    i_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serv_rf_ram_arb.md
# serv_rf_ram_arb

Arbiter that lets two requesters share one RF RAM interface: requester 0 is the SERV integer core, requester 1 is the FPU extension. It latches the single-cycle read/write request pulses from each requester and grants one requester at a time. It forwards the granted request to the RAM interface, returns that interface's ready to the granted requester only, and holds the address/data mux for a fixed transfer window. It sits between the two register-file front ends and the RF RAM interface.

## Interface
- W, 1: serial data width per register port.
- raw, 6: register address width.
- LEN, 36: data-phase length in cycles after ready; must cover the full W-bit serial transfer plus the RAM interface pipeline.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_rreq  in  2  read request pulse, bit N = requester N.
- i_req_wreq  in  2  write request pulse, bit N = requester N.
- o_req_ready  out  2  ready to requester N.
- i_req_rreg0, i_req_rreg1  in  2*raw  read register addresses, slice N = requester N.
- i_req_wreg0, i_req_wreg1  in  2*raw  write register addresses.
- i_req_wen0, i_req_wen1  in  2  write enables.
- i_req_wdata0, i_req_wdata1  in  2*W  serial write data.
- o_req_rdata0, o_req_rdata1  out  W  read data, broadcast to both requesters.
- o_rreq, o_wreq  out  1  request pulse to the RAM interface.
- i_ready  in  1  ready from the RAM interface.
- o_rreg0, o_rreg1, o_wreg0, o_wreg1  out  raw  muxed addresses.
- o_wen0, o_wen1  out  1  muxed write enables.
- o_wdata0, o_wdata1  out  W  muxed write data.
- i_rdata0, i_rdata1  in  W  read data from the RAM interface.
- o_busy  out  1  high when the state is not IDLE.

## Operation
- Pending flags pend_r[1:0] and pend_w[1:0] are set by a high request bit and cleared when that request issues. A request pulse arriving while the same flag is already set is absorbed; there is no error.
- Within one requester, write has priority over read.
- **IDLE**
  - Pending flags are considered only after they have been latched.
  - If any flag is set: select a winner, register gnt, clear the winner's flag, and drive o_wreq or o_rreq high in the next cycle. Go to PEND.
- **PEND**
  - o_*req is high only in the first PEND cycle.
  - Wait for i_ready. When i_ready is high, o_req_ready[gnt] = 1 in that same cycle (combinational). Load cnt = LEN-1 and go to XFER.
- **XFER**
  - cnt decrements every cycle. At cnt == 0, go to IDLE.
- **Muxing**
  - All muxed outputs select slice gnt combinationally in PEND and XFER.
  - In IDLE they select slice gnt and o_wen0/o_wen1 are forced to 0.
  - Read data is broadcast unmuxed; a requester without a grant never sees ready, so it ignores the data.
- **Winner selection:** round-robin. On a tie, the requester not granted last wins.
- **Requests during the other requester's transfer:** latched and served afterwards.
- **Simultaneous events:** a request pulse in the same cycle a flag is cleared by issue re-sets the flag.
- **Reset:** asserting i_rst_n low at any time forces IDLE immediately.
  - Reset values: pend = 0, gnt = 0, last = 1 (so requester 0 wins the first tie), cnt = 0.
  - Output reset values: o_rreq = 0, o_wreq = 0, o_req_ready = 0, o_busy = 0, o_wen0/o_wen1 = 0.

## Timing
- Request pulse in cycle t: flag set at the end of t, winner selected in t+1, o_*req high in t+2 (minimum latency 2).
- i_ready in cycle r: o_req_ready high in r; XFER spans r+1 .. r+LEN; IDLE at r+LEN+1.
- Earliest next o_*req: r+LEN+2.
- o_rreq, o_wreq, gnt and o_busy are registered; o_req_ready and the muxes are combinational.
- A stuck-low i_ready holds PEND indefinitely; there is no timeout.

## Configuration
- RF_ARB_FIXED_PRIO_EN
  - Defined: requester 0 (core) always wins ties, and the last register is removed.
  - Undefined: round-robin as described in Operation.

## Test plan
- Requester 0 pulses rreq at cycle 5; i_ready at 9 -> o_rreq at 7 only; o_req_ready = 2'b01 at 9; o_busy low at 46 (LEN = 36).
- Both requesters pulse wreq at cycle 5 after reset -> requester 0 served first. Requester 1's o_wreq appears 2 cycles after requester 0's XFER ends. o_wen0 follows i_req_wen0[1] during requester 1's transfer.
- Requester 1 pulses rreq during requester 0's XFER -> served immediately after, with no lost request; o_rdata0 equals i_rdata0 throughout.
- Requester 0 pulses rreq and wreq in the same cycle -> o_wreq issues first, then o_rreq after its transfer.
- i_rst_n dropped mid-XFER -> o_busy = 0, o_wen0/o_wen1 = 0 and o_req_ready = 0 immediately; pending requests are lost.
- With RF_ARB_FIXED_PRIO_EN, repeated simultaneous requests -> requester 0 wins every tie. Without it, grants alternate 0,1,0,1.
